// File: rtl/miniRISC_pkg.sv
// Shared miniRISC definitions: branch opcodes, ALU flag layout and the
// 2-bit saturating predictor counter encoding with its update rule.
package miniRISC_pkg;

  localparam int MR_OPC_W = 6;

  localparam logic [MR_OPC_W-1:0] OP_BLTZ = 6'b000111;
  localparam logic [MR_OPC_W-1:0] OP_BZ   = 6'b001000;
  localparam logic [MR_OPC_W-1:0] OP_BNZ  = 6'b001001;
  localparam logic [MR_OPC_W-1:0] OP_BR   = 6'b001010;
  localparam logic [MR_OPC_W-1:0] OP_B    = 6'b001011;
  localparam logic [MR_OPC_W-1:0] OP_BL   = 6'b001100;
  localparam logic [MR_OPC_W-1:0] OP_BCY  = 6'b001101;
  localparam logic [MR_OPC_W-1:0] OP_BNCY = 6'b001110;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
  } flags_t;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not-taken
    CTR_WNT = 2'b01,  // weakly not-taken (reset value)
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_t;

  // Saturating step: taken counts up to CTR_ST, not-taken down to CTR_SNT.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != CTR_ST) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup, flag-write and branch-resolve signals of the predictor.
// master drives requests (core side), slave is the predictor.
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32,
  parameter int OPC_W  = 6
);
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_taken;

  logic              flag_we;
  logic              sign_in;
  logic              zero_in;
  logic              carry_in;

  logic              res_valid;
  logic [OPC_W-1:0]  res_opcode;
  logic [ADDR_W-1:0] res_pc;
  logic [ADDR_W-1:0] res_target;
  logic              res_pred;

  logic              branch_valid;
  logic              mispredict;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic              link_we;
  logic [ADDR_W-1:0] link_addr;

  modport master (
    output fetch_valid, fetch_pc, flag_we, sign_in, zero_in, carry_in,
           res_valid, res_opcode, res_pc, res_target, res_pred,
    input  pred_taken, branch_valid, mispredict, flush, redirect_pc,
           link_we, link_addr
  );

  modport slave (
    input  fetch_valid, fetch_pc, flag_we, sign_in, zero_in, carry_in,
           res_valid, res_opcode, res_pc, res_target, res_pred,
    output pred_taken, branch_valid, mispredict, flush, redirect_pc,
           link_we, link_addr
  );
endinterface

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters. The read port is combinational off
// the stored state, so a lookup in the same cycle as an update to the
// same entry sees the pre-update value.
module bp_counter_table
  import miniRISC_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output ctr_t             rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int ENTRIES = 1 << IDX_W;

  ctr_t ctr_q [ENTRIES];

  assign rd_ctr_o = ctr_q[rd_idx_i];

  // Counter storage: all entries weakly not-taken on reset, RMW on update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor / resolver: flag register, branch condition evaluation,
// registered resolve results and a bimodal counter table for fetch lookup.
module branch_predict_unit
  import miniRISC_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int OPC_W  = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);

  flags_t            flags_q;
  logic              pred_taken_q;
  logic              branch_valid_q, branch_valid_d;
  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;

  logic              is_cond, is_uncond, is_bl, cond_taken, taken, hit;
  logic [ADDR_W-1:0] pc_plus4;
  ctr_t              rd_ctr;

  // Only PC[IDX_W+1:2] selects a table entry; the rest is ignored.
  logic unused_fetch_pc;
  assign unused_fetch_pc = ^{bus.fetch_pc[ADDR_W-1:IDX_W+2], bus.fetch_pc[1:0]};

  // Opcode decode and condition evaluation against the stored (old) flags.
  always_comb begin
    is_cond    = 1'b0;
    is_uncond  = 1'b0;
    is_bl      = 1'b0;
    cond_taken = 1'b0;
    case (bus.res_opcode)
      OPC_W'(OP_BCY):  begin is_cond = 1'b1; cond_taken = flags_q.carry;  end
      OPC_W'(OP_BNCY): begin is_cond = 1'b1; cond_taken = !flags_q.carry; end
      OPC_W'(OP_BLTZ): begin is_cond = 1'b1; cond_taken = flags_q.sign;   end
      OPC_W'(OP_BZ):   begin is_cond = 1'b1; cond_taken = flags_q.zero;   end
      OPC_W'(OP_BNZ):  begin is_cond = 1'b1; cond_taken = !flags_q.zero;  end
      OPC_W'(OP_BR),
      OPC_W'(OP_B):    is_uncond = 1'b1;
      OPC_W'(OP_BL):   begin is_uncond = 1'b1; is_bl = 1'b1; end
      default: ;
    endcase
  end

  assign taken    = is_uncond | cond_taken;
  assign hit      = bus.res_valid & (is_cond | is_uncond);
  assign pc_plus4 = bus.res_pc + ADDR_W'(4);

  // Next values for the resolve outputs; anything not firing reads as zero.
  always_comb begin
    branch_valid_d = hit & taken;
    mispredict_d   = hit & (taken != bus.res_pred);
    redirect_pc_d  = '0;
    if (mispredict_d) redirect_pc_d = taken ? bus.res_target : pc_plus4;
    link_we_d      = bus.res_valid & is_bl;
    link_addr_d    = link_we_d ? pc_plus4 : '0;
  end

  // Flag register and registered resolve outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q        <= '0;
      branch_valid_q <= 1'b0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
      link_we_q      <= 1'b0;
      link_addr_q    <= '0;
    end else begin
      if (bus.flag_we) flags_q <= '{sign: bus.sign_in, zero: bus.zero_in, carry: bus.carry_in};
      branch_valid_q <= branch_valid_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
      link_we_q      <= link_we_d;
      link_addr_q    <= link_addr_d;
    end
  end

  // Fetch prediction: counter MSB captured on a lookup, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pred_taken_q <= 1'b0;
    else if (bus.fetch_valid) pred_taken_q <= (rd_ctr == CTR_WT) || (rd_ctr == CTR_ST);
  end

  bp_counter_table #(.IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (bus.fetch_pc[IDX_W+1:2]),
    .rd_ctr_o   (rd_ctr),
    .upd_en_i   (bus.res_valid & is_cond),
    .upd_idx_i  (bus.res_pc[IDX_W+1:2]),
    .upd_taken_i(cond_taken)
  );

  assign bus.pred_taken   = pred_taken_q;
  assign bus.branch_valid = branch_valid_q;
  assign bus.mispredict   = mispredict_q;
  assign bus.flush        = mispredict_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.link_we      = link_we_q;
  assign bus.link_addr    = link_addr_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: vector table of single resolves plus
// hand sequences for counter training, same-cycle hazards and reset.
module tb_branch_predict_unit;
  import miniRISC_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.ADDR_W(32), .OPC_W(6)) bus ();

  branch_predict_unit #(.ADDR_W(32), .IDX_W(4), .OPC_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [5:0]  op;
    logic [2:0]  sca;   // {sign, zero, carry} loaded before the resolve
    logic        pred;
    logic [31:0] pc;
    logic        bv;
    logic        mp;
    logic        lwe;
  } vec_t;

  typedef struct {
    logic        bv;
    logic        mp;
    logic        fl;
    logic [31:0] rpc;
    logic        lwe;
    logic [31:0] la;
  } exp_t;

  vec_t vecs [13];
  exp_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no_expected_entry expected=entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, ".branch_valid"}, 32'(bus.branch_valid), 32'(e.bv));
      check({name, ".mispredict"},   32'(bus.mispredict),   32'(e.mp));
      check({name, ".flush"},        32'(bus.flush),        32'(e.fl));
      check({name, ".redirect_pc"},  bus.redirect_pc,       e.rpc);
      check({name, ".link_we"},      32'(bus.link_we),      32'(e.lwe));
      check({name, ".link_addr"},    bus.link_addr,         e.la);
    end
  endtask

  task automatic idle_inputs();
    bus.fetch_valid = 1'b0; bus.fetch_pc  = 32'd0;
    bus.flag_we     = 1'b0; bus.sign_in   = 1'b0; bus.zero_in = 1'b0; bus.carry_in = 1'b0;
    bus.res_valid   = 1'b0; bus.res_opcode = 6'd0; bus.res_pc = 32'd0;
    bus.res_target  = 32'd0; bus.res_pred = 1'b0;
  endtask

  task automatic check_outs_zero(input string name);
    check({name, ".bits"}, 32'({bus.pred_taken, bus.branch_valid, bus.mispredict,
                                bus.flush, bus.link_we}), 32'd0);
    check({name, ".redirect_pc"}, bus.redirect_pc, 32'd0);
    check({name, ".link_addr"},   bus.link_addr,   32'd0);
  endtask

  // Reset asserted just after an edge; released just after a later edge so
  // the very next edge is the first one out of reset.
  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1 check_outs_zero("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_flags(input logic [2:0] sca);
    @(negedge clk);
    bus.flag_we = 1'b1;
    {bus.sign_in, bus.zero_in, bus.carry_in} = sca;
    @(posedge clk); #1;
    bus.flag_we = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp, input string name);
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    check(name, 32'(bus.pred_taken), 32'(exp));
  endtask

  task automatic res_step(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pred, input logic fwe, input logic [2:0] sca,
                          input logic ebv, input logic emp, input logic elwe, input string name);
    exp_t e;
    @(negedge clk);
    bus.res_valid  = 1'b1;
    bus.res_opcode = op;
    bus.res_pc     = pc;
    bus.res_target = tgt;
    bus.res_pred   = pred;
    bus.flag_we    = fwe;
    {bus.sign_in, bus.zero_in, bus.carry_in} = sca;
    e.bv  = ebv;
    e.mp  = emp;
    e.fl  = emp;
    e.rpc = emp ? (ebv ? tgt : pc + 32'd4) : 32'd0;
    e.lwe = elwe;
    e.la  = elwe ? pc + 32'd4 : 32'd0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    bus.flag_we   = 1'b0;
    compare_out(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op        {s,z,c}  pred  pc             bv    mp    lwe
    vecs[0]  = '{OP_BCY,  3'b001, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{OP_BCY,  3'b110, 1'b1, 32'h0000_0204, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{OP_BNCY, 3'b000, 1'b0, 32'h0000_0208, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{OP_BLTZ, 3'b100, 1'b1, 32'h0000_020C, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{OP_BLTZ, 3'b011, 1'b0, 32'h0000_0210, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_BZ,   3'b010, 1'b1, 32'h0000_0214, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{OP_BNZ,  3'b010, 1'b0, 32'h0000_0218, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_BNZ,  3'b000, 1'b0, 32'h0000_021C, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{OP_BR,   3'b000, 1'b0, 32'h0000_0220, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{OP_B,    3'b000, 1'b1, 32'h0000_0224, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_BL,   3'b000, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{6'h00,   3'b111, 1'b1, 32'h0000_0228, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{6'h3F,   3'b111, 1'b0, 32'h0000_022C, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    do_reset();

    for (int i = 0; i < 13; i++) begin
      set_flags(vecs[i].sca);
      res_step(vecs[i].op, vecs[i].pc, 32'h1000 + 32'(i) * 32'd16, vecs[i].pred, 1'b0,
               3'b000, vecs[i].bv, vecs[i].mp, vecs[i].lwe, $sformatf("vec%0d", i));
    end

    // Fresh lookup after reset, then bz training at 0x10.
    do_reset();
    lookup(32'h10, 1'b0, "first_lookup");
    set_flags(3'b010);
    res_step(OP_BZ, 32'h10, 32'h80, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "bz1");
    res_step(OP_BZ, 32'h10, 32'h80, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "bz2");
    lookup(32'h10, 1'b1, "bz_trained");
    res_step(OP_BZ, 32'h10, 32'h80, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "bz3");
    @(posedge clk); #1;
    check_outs_zero_but_pred("idle_after_bz");
    repeat (2) @(posedge clk);
    #1 check("pred_held", 32'(bus.pred_taken), 32'd1);

    // Lookup and update of the same entry in one cycle.
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h20;
    res_step(OP_BZ, 32'h20, 32'h90, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "bz_same_cycle");
    bus.fetch_valid = 1'b0;
    check("same_cycle_pre_update", 32'(bus.pred_taken), 32'd0);
    lookup(32'h20, 1'b1, "same_cycle_post_update");

    // Same-cycle flag write is not seen by the resolving bcy; also relies on
    // the flag register having been cleared by reset.
    do_reset();
    res_step(OP_BCY, 32'h30, 32'h300, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, "bcy_old_flag");
    res_step(OP_BCY, 32'h30, 32'h300, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "bcy_new_flag");

    res_step(OP_BL, 32'hFFFF_FFFC, 32'h400, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, "bl_wrap");

    // Saturation high then low on entry 0x40.
    set_flags(3'b000);
    for (int k = 0; k < 5; k++)
      res_step(OP_BNZ, 32'h40, 32'h500, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, $sformatf("bnz_t%0d", k));
    set_flags(3'b010);
    res_step(OP_BNZ, 32'h40, 32'h500, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, "bnz_nt_after_sat");
    lookup(32'h40, 1'b1, "sat_high_then_dec");
    for (int k = 0; k < 4; k++)
      res_step(OP_BNZ, 32'h40, 32'h500, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, $sformatf("bnz_nt%0d", k));
    set_flags(3'b000);
    res_step(OP_BNZ, 32'h40, 32'h500, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "bnz_t_after_low");
    lookup(32'h40, 1'b0, "sat_low_then_inc");

    // Unconditional and non-branch resolves leave the table alone.
    res_step(OP_B, 32'h50, 32'h600, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "b_no_upd0");
    res_step(OP_B, 32'h50, 32'h600, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "b_no_upd1");
    lookup(32'h50, 1'b0, "uncond_no_update");
    set_flags(3'b010);
    res_step(OP_BZ, 32'h60, 32'h700, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "bz_0x60");
    res_step(6'h3F, 32'h60, 32'h700, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, "nonbr_0x60");
    lookup(32'h60, 1'b1, "nonbranch_no_update");

    // Reset landing on a pending flush pulse.
    res_step(OP_BZ, 32'h10, 32'h80, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "bz_pre_rst0");
    res_step(OP_BZ, 32'h10, 32'h80, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, "bz_pre_rst1");
    lookup(32'h10, 1'b1, "pre_rst_trained");
    @(negedge clk);
    bus.res_valid = 1'b1; bus.res_opcode = OP_BZ; bus.res_pc = 32'h10;
    bus.res_target = 32'h80; bus.res_pred = 1'b0;
    @(posedge clk); #1;
    check("flush_before_rst", 32'(bus.flush), 32'd1);
    bus.res_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_outs_zero("rst_mid_resolve");
    @(posedge clk); #1;
    rst_n = 1'b1;
    lookup(32'h10, 1'b0, "rst_ctr_msb");
    set_flags(3'b010);
    res_step(OP_BZ, 32'h10, 32'h80, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, "bz_post_rst");
    lookup(32'h10, 1'b1, "rst_ctr_was_01");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check_outs_zero_but_pred(input string name);
    check({name, ".bits"}, 32'({bus.branch_valid, bus.mispredict, bus.flush, bus.link_we}), 32'd0);
    check({name, ".redirect_pc"}, bus.redirect_pc, 32'd0);
    check({name, ".link_addr"},   bus.link_addr,   32'd0);
  endtask

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning PC/target width in bits.
REQ-002 The module SHALL have parameter IDX_W, default 4, meaning the predictor table has 2**IDX_W entries indexed by PC[IDX_W+1:2].
REQ-003 The module SHALL have parameter OPC_W, default 6, meaning opcode width.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset, with ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-005 The module SHALL have these ports: fetch_valid in 1, lookup request; fetch_pc in ADDR_W, lookup PC; pred_taken out 1, registered prediction.
REQ-006 The module SHALL have these flag ports: flag_we in 1, ALU flag write; sign_in, zero_in, carry_in in 1 each, ALU flags.
REQ-007 The module SHALL have these resolve ports: res_valid in 1; res_opcode in OPC_W; res_pc in ADDR_W; res_target in ADDR_W; res_pred in 1, the prediction originally issued.
REQ-008 The module SHALL have these result ports: branch_valid out 1, resolved taken; mispredict out 1; flush out 1; redirect_pc out ADDR_W; link_we out 1; link_addr out ADDR_W.

Function
REQ-009 The module SHALL decode opcodes bcy=001101, bncy=001110, bltz=000111, bz=001000, bnz=001001 as conditional, and br=001010, b=001011, bl=001100 as unconditional; all other opcodes are non-branch.
REQ-010 The module SHALL hold a flag register {sign,zero,carry}, loaded on flag_we.
REQ-011 Conditional branches SHALL resolve taken as: bcy carry=1; bncy carry=0; bltz sign=1; bz zero=1; bnz zero=0.
REQ-012 Conditional resolution SHALL use the flag register value before any same-cycle flag_we update.
REQ-013 Unconditional branches SHALL always resolve taken.
REQ-014 Resolve latency SHALL be 1 cycle: outputs are registered on the edge that samples res_valid=1, and deasserted otherwise.
REQ-015 mispredict and flush SHALL be one-cycle pulses, asserted when res_valid, the opcode is a branch, and taken != res_pred.
REQ-016 redirect_pc SHALL be res_target if taken, else res_pc+4 modulo 2**ADDR_W; it is valid only while flush=1 and holds 0 otherwise.
REQ-017 For bl, link_we SHALL pulse with link_addr = res_pc+4 (wraps); link_addr holds 0 otherwise.
REQ-018 A non-branch opcode with res_valid SHALL produce all result outputs 0 and no table update.
REQ-019 The predictor table SHALL hold 2-bit saturating counters: taken increments, saturating at 11; not-taken decrements, saturating at 00.
REQ-020 Only conditional branches SHALL update the predictor table.
REQ-021 pred_taken SHALL be registered as counter[MSB] of the fetch_pc entry, 1 cycle after fetch_valid, and held when fetch_valid=0.
REQ-022 Unconditional opcodes SHALL NOT influence the prediction.
REQ-023 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update counter.

Reset
REQ-024 While rst_n=0, all counters SHALL be 01 (weakly not-taken), the flag register 000, and every output 0.
REQ-025 Reset assertion mid-resolve SHALL cancel any pending pulse.
REQ-026 The first rising edge after rst_n deasserts SHALL operate normally.

Structure
REQ-027 The opcode constants and the 2-bit counter encodings SHALL live in the shared package miniRISC_pkg.
REQ-028 The predictor table SHALL be a sub-module bp_counter_table with one read port and one read-modify-write update port.
REQ-029 Condition evaluation SHALL remain in the top module.

Verification
REQ-030 Reset, then fetch_pc=0x10 -> pred_taken=0 next cycle.
REQ-031 Run bz at res_pc=0x10 with zero=1 and res_pred=0, three times -> branch_valid=1, mispredict=1 and redirect_pc=res_target on each; after the second, a lookup of 0x10 gives pred_taken=1.
REQ-032 flag_we with carry_in=1 in the same cycle as bcy (old carry=0), res_pred=0 -> branch_valid=0, no flush; the next bcy -> taken.
REQ-033 bl at res_pc=0xFFFFFFFC, res_pred=1 -> link_we=1, link_addr=0x0, mispredict=0.
REQ-034 bnz with zero=0 repeated 5 times -> counter saturates at 11; then zero=1 -> counter becomes 10, mispredict=1 when res_pred=1, redirect_pc=res_pc+4.
REQ-035 Assert rst_n=0 in the cycle after res_valid -> flush=0 immediately, and all counters read back 01.
